next_level_arbiter: RTL and testbench
=====================================

Name: next_level_arbiter

Overview:
- Arbitrates the single next-level (L2) request port between the instruction-cache miss path and the data-cache miss/write-back path.
- Each requester presents a 26-bit line address (address bits 31:6); the block grants one requester at a time with round-robin fairness.
- It drives a request/acknowledge transaction to the next level, returns a one-cycle completion pulse to the winner and counts grants per side.

Parameters:
- ADDR_W, 26, line-address width (byte address bits 31:6).
- TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ack before aborting; 1..255.
- CNT_W, 32, width of the grant statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ireq  in  1  instruction-cache miss request; held high until idone.
- iaddr  in  ADDR_W  instruction line address; stable while ireq is high.
- dreq  in  1  data-cache request; held high until ddone.
- daddr  in  ADDR_W  data line address; stable while dreq is high.
- dwe  in  1  1 = write-back, 0 = line fill; stable while dreq is high.
- idone  out  1  one-cycle completion pulse to the instruction cache.
- ddone  out  1  one-cycle completion pulse to the data cache.
- err  out  1  one-cycle pulse, coincident with idone/ddone, when the transaction timed out.
- mem_req  out  1  next-level request; held until acknowledged.
- mem_addr  out  ADDR_W  registered address of the granted requester.
- mem_we  out  1  registered write flag (always 0 for instruction grants).
- mem_ack  in  1  next-level acknowledge; sampled only while mem_req is high.
- gnt_cnt_i  out  CNT_W  instruction-side grant count.
- gnt_cnt_d  out  CNT_W  data-side grant count.

Behaviour:
- Reset (rst_n low at an edge): state IDLE; mem_req, idone, ddone, err, mem_we = 0; mem_addr = 0; gnt_cnt_i, gnt_cnt_d = 0; last_gnt = D; timer = 0. Reset has priority over everything. A reset mid-transaction abandons it silently: no done pulse is generated.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Only ireq high: grant I.
  - Only dreq high: grant D.
  - Both high: grant the side that is not last_gnt.
  - On a grant: capture address (and dwe for D, 0 for I) into mem_addr/mem_we; set mem_req = 1; update last_gnt; increment that side's counter; clear the timer; go to BUSY.
- BUSY:
  - mem_req stays 1 and the timer increments each cycle.
  - mem_ack = 1: mem_req goes to 0 at that edge; go to DONE with err = 0.
  - Timer reaches TIMEOUT_CYCLES with no ack: mem_req goes to 0; go to DONE with err = 1.
  - If ack and timeout occur on the same edge, the ack wins (err = 0).
- DONE:
  - The granted side's done output is high for exactly this one cycle; err is valid in this cycle.
  - Next edge: return to IDLE. Arbitration resumes in IDLE, so back-to-back grants are spaced at least 3 cycles apart.
- Latency: request seen at edge 0 gives mem_req high after edge 0; mem_ack at edge k gives done high for the cycle after edge k.
- Requester dropping req:
  - Before grant: ignored, no effect.
  - After grant: the transaction still completes and done still pulses; the requester must tolerate it.
- mem_ack outside BUSY is ignored.
- Counters wrap modulo 2^CNT_W without saturation.
- mem_addr/mem_we hold their last value when idle.

Optional Feature:
- Macro: NLA_STATS_EN.
- Defined: gnt_cnt_i and gnt_cnt_d are implemented as described.
- Undefined: no counter flops are built; both outputs are tied to 0. Ports remain so the interface is unchanged.

Decomposition:
- Shared package nla_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - Requester id encoding (I = 0, D = 1).
  - ADDR_W default 26.
  - Trace command codes shared with the caches: RESET 8, INVALIDATE 3, INST_FETCH 2, PRINT 9.
- One natural sub-module: nla_rr_pick. It is combinational 2-way round-robin selection from (ireq, dreq, last_gnt) to (valid, id). All state stays in the top module.

Test Plan:
- Reset then ireq = 1, iaddr = 26'h0ABCDE, mem_ack asserted 2 cycles after mem_req -> mem_addr = 26'h0ABCDE, mem_we = 0; idone pulses exactly 1 cycle; err = 0; gnt_cnt_i = 1.
- ireq and dreq both held high (dwe = 1, daddr = 26'h1234) with immediate acks -> grant order I, D, I, D; mem_we = 1 only on D grants; after 4 transactions gnt_cnt_i = gnt_cnt_d = 2.
- TIMEOUT_CYCLES = 4, dreq high, mem_ack never asserted -> mem_req high for exactly 4 cycles; ddone and err pulse together; state returns to IDLE.
- mem_ack arriving on the same edge as timeout expiry -> err = 0, normal done.
- rst_n low for 1 cycle while in BUSY -> no idone/ddone; all outputs 0 and counters 0 on the next cycle; pending ireq is granted again after reset.
- Build without NLA_STATS_EN and run the 4-transaction round-robin case -> gnt_cnt_i = gnt_cnt_d = 0; grant sequence is identical to the build with the macro defined.

Source files
------------

// File: rtl/nla_pkg.sv
// Shared types for the next-level (L2) request arbiter.
// State encoding, requester ids, default widths and cache trace command codes.
package nla_pkg;

  localparam int NLA_ADDR_W = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  typedef enum logic [3:0] {
    CMD_INST_FETCH = 4'd2,
    CMD_INVALIDATE = 4'd3,
    CMD_RESET      = 4'd8,
    CMD_PRINT      = 4'd9
  } trace_cmd_e;

endpackage

// File: rtl/nla_rr_pick.sv
// Two-way round-robin pick between I-cache and D-cache requests.
// In: ireq, dreq, last_gnt. Out: valid (any request), id (winner).
module nla_rr_pick
  import nla_pkg::*;
(
  input  logic    ireq,
  input  logic    dreq,
  input  req_id_e last_gnt,
  output logic    valid,
  output req_id_e id
);

  always_comb begin
    valid = ireq | dreq;
    unique case ({ireq, dreq})
      2'b10:   id = REQ_I;
      2'b01:   id = REQ_D;
      2'b11:   id = (last_gnt == REQ_D) ? REQ_I : REQ_D;
      default: id = REQ_I;
    endcase
  end

endmodule

// File: rtl/next_level_arbiter.sv
// Arbitrates the L2 request port between I-cache misses and D-cache
// misses/write-backs: round-robin grant, req/ack with timeout, done pulse.
// Ports: clk, rst_n (sync, active-low); ireq/iaddr, dreq/daddr/dwe in;
// idone/ddone/err pulses; mem_req/mem_addr/mem_we out, mem_ack in;
// gnt_cnt_i/gnt_cnt_d grant counters, built only with NLA_STATS_EN.
module next_level_arbiter
  import nla_pkg::*;
#(
  parameter int ADDR_W         = NLA_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dreq,
  input  logic [ADDR_W-1:0] daddr,
  input  logic              dwe,
  output logic              idone,
  output logic              ddone,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  gnt_cnt_i,
  output logic [CNT_W-1:0]  gnt_cnt_d
);

  localparam int TW = 8;
  // Timer counts completed BUSY edges; expiry is on the edge that
  // would bring it to TIMEOUT_CYCLES.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  req_id_e           last_gnt_q, last_gnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic              idone_q, idone_d;
  logic              ddone_q, ddone_d;
  logic              err_q, err_d;

  logic    pick_valid;
  req_id_e pick_id;

  nla_rr_pick u_pick (
    .ireq     (ireq),
    .dreq     (dreq),
    .last_gnt (last_gnt_q),
    .valid    (pick_valid),
    .id       (pick_id)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    timer_d    = timer_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = mem_we_q;
    idone_d    = 1'b0;
    ddone_d    = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = BUSY;
          mem_req_d  = 1'b1;
          timer_d    = '0;
          last_gnt_d = pick_id;
          if (pick_id == REQ_D) begin
            mem_addr_d = daddr;
            mem_we_d   = dwe;
          end else begin
            mem_addr_d = iaddr;
            mem_we_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        timer_d = timer_q + TW'(1);
        // Ack beats a coincident timeout.
        if (mem_ack || (timer_q == TMO_LAST)) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = ~mem_ack;
          idone_d   = (last_gnt_q == REQ_I);
          ddone_d   = (last_gnt_q == REQ_D);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= REQ_D;
      timer_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      idone_q    <= 1'b0;
      ddone_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      timer_q    <= timer_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      idone_q    <= idone_d;
      ddone_q    <= ddone_d;
      err_q      <= err_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign idone    = idone_q;
  assign ddone    = ddone_q;
  assign err      = err_q;

`ifdef NLA_STATS_EN
  logic [CNT_W-1:0] cnt_i_q, cnt_i_d;
  logic [CNT_W-1:0] cnt_d_q, cnt_d_d;
  logic             grant;

  always_comb begin
    grant   = (state_q == IDLE) && pick_valid;
    cnt_i_d = cnt_i_q;
    cnt_d_d = cnt_d_q;
    if (grant && (pick_id == REQ_I)) cnt_i_d = cnt_i_q + CNT_W'(1);
    if (grant && (pick_id == REQ_D)) cnt_d_d = cnt_d_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_i_q <= '0;
      cnt_d_q <= '0;
    end else begin
      cnt_i_q <= cnt_i_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  assign gnt_cnt_i = cnt_i_q;
  assign gnt_cnt_d = cnt_d_q;
`else
  assign gnt_cnt_i = '0;
  assign gnt_cnt_d = '0;
`endif

endmodule

// File: tb/tb_next_level_arbiter.sv
// Scoreboard bench for next_level_arbiter (TIMEOUT_CYCLES = 4).
// Grant and done expectations are queued at stimulus, checked at DUT output.
module tb_next_level_arbiter;

  localparam int AW = 26;
  localparam int CW = 32;

  logic          clk;
  logic          rst_n;
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic          dreq;
  logic [AW-1:0] daddr;
  logic          dwe;
  logic          idone;
  logic          ddone;
  logic          err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_ack;
  logic [CW-1:0] gnt_cnt_i;
  logic [CW-1:0] gnt_cnt_d;

  next_level_arbiter #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (4),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ireq      (ireq),
    .iaddr     (iaddr),
    .dreq      (dreq),
    .daddr     (daddr),
    .dwe       (dwe),
    .idone     (idone),
    .ddone     (ddone),
    .err       (err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .gnt_cnt_i (gnt_cnt_i),
    .gnt_cnt_d (gnt_cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    int            len;
  } gnt_t;

  typedef struct {
    logic id;
    logic err;
  } done_t;

  gnt_t  gnt_q[$];
  done_t done_q[$];
  gnt_t  cur;
  logic  cur_ok;
  logic  prev_req;
  logic  prev_done;
  int    rlen;
  int    rcnt;
  int    ack_lat;
  int    i_left;
  int    d_left;
  int    exp_ci;
  int    exp_cd;
  int    n_chk;
  int    n_pass;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [63:0] ecnt(input int v);
`ifdef NLA_STATS_EN
    return 64'(v);
`else
    return 64'(v) & 64'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Next-level responder: ack during the ack_lat-th cycle of mem_req.
  always @(negedge clk) begin
    if (!rst_n || !mem_req) begin
      rcnt    = 0;
      mem_ack = 1'b0;
    end else begin
      rcnt++;
      mem_ack = (ack_lat != 0) && (rcnt == ack_lat);
    end
  end

  // Output monitor and requester model.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
      rlen      = 0;
      cur_ok    = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        chk("gnt_expected", 64'(gnt_q.size() != 0), 64'd1);
        if (gnt_q.size() != 0) begin
          cur    = gnt_q.pop_front();
          cur_ok = 1'b1;
          chk("gnt_addr", 64'(mem_addr), 64'(cur.addr));
          chk("gnt_we", 64'(mem_we), 64'(cur.we));
        end
        rlen = 0;
      end
      if (mem_req) rlen++;
      if (!mem_req && prev_req && cur_ok) begin
        chk("req_len", 64'(rlen), 64'(cur.len));
        cur_ok = 1'b0;
      end
      if (err) chk("err_with_done", 64'(idone | ddone), 64'd1);
      if (idone || ddone) begin
        done_t d;
        chk("done_1cyc", 64'(prev_done), 64'd0);
        chk("done_excl", 64'(idone & ddone), 64'd0);
        chk("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          chk("done_id", 64'(ddone), 64'(d.id));
          chk("done_err", 64'(err), 64'(d.err));
        end
        if (idone && i_left > 0) begin
          i_left--;
          ireq = (i_left > 0);
        end
        if (ddone && d_left > 0) begin
          d_left--;
          dreq = (d_left > 0);
        end
      end
      prev_req  = mem_req;
      prev_done = idone | ddone;
    end
  end

  task automatic push(input logic [AW-1:0] a, input logic we,
                      input int len, input logic id, input logic e);
    gnt_t  g;
    done_t d;
    g.addr = a;
    g.we   = we;
    g.len  = len;
    d.id   = id;
    d.err  = e;
    gnt_q.push_back(g);
    done_q.push_back(d);
    if (id) exp_cd++;
    else    exp_ci++;
  endtask

  task automatic chk_rst(input string tag);
    @(negedge clk);
    chk({tag, "_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_idone"}, 64'(idone), 64'd0);
    chk({tag, "_ddone"}, 64'(ddone), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_cnt_i"}, 64'(gnt_cnt_i), 64'd0);
    chk({tag, "_cnt_d"}, 64'(gnt_cnt_d), 64'd0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ireq   = 1'b0;
    dreq   = 1'b0;
    i_left = 0;
    d_left = 0;
    gnt_q.delete();
    done_q.delete();
    exp_ci = 0;
    exp_cd = 0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((i_left > 0 || d_left > 0 || done_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_drain_done"}, 64'(done_q.size()), 64'd0);
    chk({tag, "_drain_gnt"}, 64'(gnt_q.size()), 64'd0);
    repeat (2) tick();
  endtask

  task automatic chk_cnt(input string tag);
    @(negedge clk);
    chk({tag, "_cnt_i"}, 64'(gnt_cnt_i), ecnt(exp_ci));
    chk({tag, "_cnt_d"}, 64'(gnt_cnt_d), ecnt(exp_cd));
    tick();
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    ack_lat = 1;
    iaddr   = '0;
    daddr   = '0;
    dwe     = 1'b0;
    do_reset();
    chk_rst("rst");

    // Single I miss, ack two cycles into the request.
    tick();
    ack_lat = 2;
    iaddr   = 26'h0ABCDE;
    push(26'h0ABCDE, 1'b0, 2, 1'b0, 1'b0);
    i_left = 1;
    ireq   = 1'b1;
    drain("single_i");
    chk_cnt("single_i");

    // Both sides held: alternate I, D, I, D.
    do_reset();
    tick();
    ack_lat = 1;
    iaddr   = 26'h0111;
    daddr   = 26'h1234;
    dwe     = 1'b1;
    push(26'h0111, 1'b0, 1, 1'b0, 1'b0);
    push(26'h1234, 1'b1, 1, 1'b1, 1'b0);
    push(26'h0111, 1'b0, 1, 1'b0, 1'b0);
    push(26'h1234, 1'b1, 1, 1'b1, 1'b0);
    i_left = 2;
    d_left = 2;
    ireq   = 1'b1;
    dreq   = 1'b1;
    drain("rr");
    chk_cnt("rr");

    // D request never acknowledged: timeout after 4 cycles.
    ack_lat = 0;
    daddr   = 26'h3FF00;
    dwe     = 1'b0;
    push(26'h3FF00, 1'b0, 4, 1'b1, 1'b1);
    d_left = 1;
    dreq   = 1'b1;
    drain("tmo");
    chk_cnt("tmo");

    // Ack on the same edge as timeout expiry: ack wins.
    ack_lat = 4;
    daddr   = 26'h2F0F0;
    dwe     = 1'b1;
    push(26'h2F0F0, 1'b1, 4, 1'b1, 1'b0);
    d_left = 1;
    dreq   = 1'b1;
    drain("ack_tmo");
    chk_cnt("ack_tmo");

    // Reset mid-BUSY: no done, then the held ireq is granted again.
    ack_lat = 0;
    iaddr   = 26'h2AAAA;
    push(26'h2AAAA, 1'b0, 99, 1'b0, 1'b0);
    void'(done_q.pop_back());
    i_left = 1;
    ireq   = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    ack_lat = 1;
    exp_ci  = 0;
    exp_cd  = 0;
    push(26'h2AAAA, 1'b0, 1, 1'b0, 1'b0);
    chk_rst("rst_busy");
    drain("rst_busy");
    chk_cnt("rst_busy");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
